// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the 4x4 keypad encoder: scanner
//               state encoding, column drive reset value, row priority and
//               key-to-code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scanner states
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Column 0 driven low out of reset
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Active-low one-hot column drive for a column index
    function automatic logic [3:0] col_drive(input logic [1:0] col);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << col;
        return ~one_hot;
    endfunction

    // Lowest-index row wins when several rows are low together
    function automatic logic [1:0] lowest_row(input logic [3:0] rows_low);
        logic [1:0] idx;
        if (rows_low[0])      idx = 2'd0;
        else if (rows_low[1]) idx = 2'd1;
        else if (rows_low[2]) idx = 2'd2;
        else                  idx = 2'd3;
        return idx;
    endfunction

    // Segment-decoder code {s3,s2,s1,s0} = {row, col}
    function automatic logic [3:0] key_code(input logic [1:0] row,
                                            input logic [1:0] col);
        return {row, col};
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick
// Description : Free-running divider emitting a one-cycle tick every SCAN_DIV
//               clock cycles, phase-aligned to the release of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..SCAN_DIV-1 and wrap; the last count is the tick cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule : scan_tick
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_encoder
// Description : 4x4 matrix keypad scanner. Drives columns, synchronizes and
//               debounces rows, and emits a 4-bit {row,col} code with a
//               one-cycle valid strobe per accepted press.
//               Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat strobes
//               every REPEAT_PERIOD cycles while the key stays pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 4,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned REPEAT_PERIOD = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] code,
    output logic       valid,
    output logic       held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DB_DONE = CNT_W'(DEBOUNCE);

    // Reject configurations the timing does not support
    if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("keypad_encoder: SCAN_DIV>=4, DEBOUNCE>=1, REPEAT_PERIOD>=1 required");
    end

    // ------------------------------------------------------------------
    // Row synchronizer (rows are asynchronous to clk)
    // ------------------------------------------------------------------
    logic [3:0] row_sync1;
    logic [3:0] row_sync2;

    // Two-flop synchronizer, idles at the pulled-up level
    always_ff @(posedge clk) begin
        if (rst) begin
            row_sync1 <= 4'hF;
            row_sync2 <= 4'hF;
        end else begin
            row_sync1 <= row_n;
            row_sync2 <= row_sync1;
        end
    end

    logic [3:0] rows_low;
    logic       any_low;

    assign rows_low = ~row_sync2;
    assign any_low  = |rows_low;

    // ------------------------------------------------------------------
    // Scan tick
    // ------------------------------------------------------------------
    logic tick;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Scanner FSM
    // ------------------------------------------------------------------
    state_t           state,   state_nx;
    logic [1:0]       col,     col_nx;
    logic [1:0]       row_sel, row_sel_nx;
    logic [CNT_W-1:0] cnt,     cnt_nx;
    logic [3:0]       code_nx;
    logic             valid_nx;
    logic             held_nx;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + 1'b1;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nx;

    // Repeat counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nx;
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_SCAN;
            col     <= 2'd0;
            col_n   <= COL_RESET;
            row_sel <= 2'd0;
            cnt     <= '0;
            code    <= 4'h0;
            valid   <= 1'b0;
            held    <= 1'b0;
        end else begin
            state   <= state_nx;
            col     <= col_nx;
            col_n   <= col_drive(col_nx);
            row_sel <= row_sel_nx;
            cnt     <= cnt_nx;
            code    <= code_nx;
            valid   <= valid_nx;
            held    <= held_nx;
        end
    end

    // Next-state logic; every decision is taken on a scan tick
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_sel_nx = row_sel;
        cnt_nx     = cnt;
        code_nx    = code;
        valid_nx   = 1'b0;
        held_nx    = held;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nx = rep_cnt;
        // Re-strobe the held key every REPEAT_PERIOD cycles
        if (state == ST_PRESSED) begin
            if (rep_cnt == REP_LAST) begin
                valid_nx   = 1'b1;
                rep_cnt_nx = '0;
            end else begin
                rep_cnt_nx = rep_cnt + 1'b1;
            end
        end
`endif

        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        // Hold the column so the same key stays visible
                        row_sel_nx = lowest_row(rows_low);
                        cnt_nx     = '0;
                        state_nx   = ST_DEBOUNCE;
                    end else begin
                        col_nx = col + 2'd1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (rows_low[row_sel]) begin
                        if (cnt_inc == DB_DONE) begin
                            state_nx = ST_PRESSED;
                            cnt_nx   = '0;
                            code_nx  = key_code(row_sel, col);
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_nx = '0;
`endif
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        // Bounce: give up and move on to the next column
                        state_nx = ST_SCAN;
                        cnt_nx   = '0;
                        col_nx   = col + 2'd1;
                    end
                end

                ST_PRESSED: begin
                    if (!any_low) begin
                        state_nx = ST_RELEASE;
                        cnt_nx   = '0;
                    end
                end

                ST_RELEASE: begin
                    if (!any_low) begin
                        if (cnt_inc == DB_DONE) begin
                            state_nx = ST_SCAN;
                            cnt_nx   = '0;
                            held_nx  = 1'b0;
                            col_nx   = col + 2'd1;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt_nx = '0;
`endif
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        // Release bounce: resume the press without a new strobe
                        state_nx = ST_PRESSED;
                        cnt_nx   = '0;
                    end
                end

                default: begin
                    state_nx = ST_SCAN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule : keypad_encoder
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_encoder
// Description : Directed self-checking bench for keypad_encoder with a
//               behavioural 4x4 key matrix. Expected cycle numbers are
//               counted from the release of reset (scan ticks on multiples
//               of 4, 2-flop sync, 3-tick debounce).
//               Honours KEYPAD_REPEAT_EN for the repeat expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] code;
    logic       valid;
    logic       held;

    logic [15:0] keys;        // key (r,c) pressed when keys[r*4+c]
    logic        bounce_low;  // forces row 0 low regardless of column

    int n_chk;
    int n_fail;
    int cyc;
    int n_strobe;
    int last_cyc;
    int last_code;
    int base;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_CLEAN_STROBES = 6;
    localparam int EXP_CLEAN_LAST    = 220;
`else
    localparam int EXP_CLEAN_STROBES = 1;
    localparam int EXP_CLEAN_LAST    = 20;
`endif

    keypad_encoder #(
        .SCAN_DIV      (4),
        .DEBOUNCE      (3),
        .REPEAT_PERIOD (40)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .row_n (row_n),
        .col_n (col_n),
        .code  (code),
        .valid (valid),
        .held  (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
        if (bounce_low) row_n[0] = 1'b0;
    end

    // Cycle count since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Strobe monitor
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            n_strobe  = n_strobe + 1;
            last_cyc  = cyc;
            last_code = int'(code);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the edge that brings cyc to n
    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) check("wait_cyc_timeout", cyc, n);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        n_strobe   = 0;
        last_cyc   = -1;
        last_code  = -1;
        keys       = 16'h0;
        bounce_low = 1'b0;
        rst        = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_n", col_n, 4'b1110);
        check("rst_code",  code,  4'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_held",  held,  1'b0);
        rst = 1'b0;

        // Clean press: key row 2 / column 1
        keys[2*4+1] = 1'b1;
        wait_cyc(21);
        check("clean_strobe_cyc",  last_cyc,  20);
        check("clean_code",        last_code, 4'b1001);
        check("clean_valid_pulse", valid,     1'b0);
        check("clean_held",        held,      1'b1);
        wait_cyc(222);
        keys = 16'h0;
        wait_cyc(239);
        check("clean_strobe_count", n_strobe, EXP_CLEAN_STROBES);
        check("clean_last_strobe",  last_cyc, EXP_CLEAN_LAST);
        check("release_held_hi",    held,     1'b1);
        wait_cyc(240);
        check("release_held_lo",    held,     1'b0);
        check("release_col_adv",    col_n,    4'b1011);

        // Bounce on row 0 for a single tick while column 2 is driven
        base = n_strobe;
        wait_cyc(241);
        bounce_low = 1'b1;
        wait_cyc(245);
        bounce_low = 1'b0;
        wait_cyc(247);
        check("bounce_col_hold", col_n, 4'b1011);
        wait_cyc(248);
        check("bounce_col_next", col_n, 4'b0111);
        check("bounce_held",     held,  1'b0);
        wait_cyc(249);
        check("bounce_no_strobe", n_strobe, base);

        // Two keys on column 2: rows 1 and 3, row 1 wins
        wait_cyc(250);
        keys[1*4+2] = 1'b1;
        keys[3*4+2] = 1'b1;
        wait_cyc(277);
        check("two_strobe_count", n_strobe,  base + 1);
        check("two_strobe_cyc",   last_cyc,  276);
        check("two_code",         last_code, 4'b0110);

        // Reset while pressed, keys still held
        wait_cyc(300);
        base = n_strobe;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_col_n", col_n, 4'b1110);
        check("midrst_code",  code,  4'h0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_held",  held,  1'b0);
        rst = 1'b0;
        wait_cyc(25);
        check("midrst_strobe_count", n_strobe,  base + 1);
        check("midrst_strobe_cyc",   last_cyc,  24);
        check("midrst_code_again",   last_code, 4'b0110);
        check("midrst_held_again",   held,      1'b1);

        keys = 16'h0;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_keypad_encoder
`default_nettype wire

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 matrix keypad and encodes the pressed key into the 4-bit code s3..s0 consumed by the per-segment seven-segment decoders. It is the producer side of the decoder path: it drives columns, samples rows, debounces, and emits one code plus a one-cycle `valid` strobe per debounced press. It sits between the board keypad pins and the display/decoder logic.

## Interface
- `SCAN_DIV`, 4: clock cycles per column dwell; minimum 4, which covers the 2-flop sync plus margin.
- `DEBOUNCE`, 3: consecutive qualifying scan ticks required to accept a press or a release; minimum 1.
- `REPEAT_PERIOD`, 40: cycles between auto-repeat strobes; used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `row_n`  in  4  keypad rows; active-low, externally pulled up, asynchronous to `clk`.
- `col_n`  out  4  column drive; active-low, one-hot-zero.
- `code`  out  4  {s3,s2,s1,s0} = {row[1:0], col[1:0]} of the accepted key.
- `valid`  out  1  one-cycle strobe; `code` is new on this cycle.
- `held`  out  1  high while an accepted key is still pressed.

## Operation
- `row_n` passes through a 2-flop synchronizer. All decisions use the synchronized value, sampled only on a scan tick.
- Scan tick: one pulse every `SCAN_DIV` cycles, counted from reset.
- States:
  - SCAN: on tick, if any row is low, latch the row index and the current column and go to DEBOUNCE; the column is not advanced. Otherwise advance the column, wrapping 3 to 0.
  - DEBOUNCE: on tick, if the latched row is still low, increment the counter. When the count reaches `DEBOUNCE`, go to PRESSED. If the latched row is high, return to SCAN and advance the column.
  - PRESSED: `held`=1. On a tick with all rows high, go to RELEASE with the counter cleared.
  - RELEASE: on tick with all rows high, increment the counter. At `DEBOUNCE`, go to SCAN, drop `held`, and advance the column. Any row low returns to PRESSED with no new `valid`.
- Multiple rows low on one column: the lowest row index wins. Other keys are ignored until release.
- `code` holds its value between strobes.
- Reset values: `col_n`=4'b1110, `code`=4'h0, `valid`=0, `held`=0, state SCAN, all counters 0, synchronizer flops 1.
- Reset mid-press: return to reset values on the next cycle. A key still held is re-detected from SCAN and produces a fresh `valid` after a full debounce.

## Timing
- `valid` and the new `code` are both registered. They appear the cycle after the tick that completes DEBOUNCE, and `valid` is high for exactly one cycle.
- `held` rises in the same cycle as `valid`. It falls the cycle after the tick that completes RELEASE.
- Worst-case press-to-strobe latency is 2 + 4·`SCAN_DIV` + `DEBOUNCE`·`SCAN_DIV` + 1 cycles.
- `col_n` changes only the cycle after a tick, which leaves `SCAN_DIV`−1 cycles of settling before the next sample.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In PRESSED, a repeat counter re-pulses `valid` with the same `code` every `REPEAT_PERIOD` cycles after the first strobe.
  - The counter clears on leaving PRESSED and is held in RELEASE.
- `KEYPAD_REPEAT_EN` undefined: exactly one `valid` per press, the repeat counter is absent, and `REPEAT_PERIOD` is ignored.

## Structure
- Package `keypad_pkg` holds:
  - the state encoding constants (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the column one-hot reset constant 4'b1110;
  - the key-to-code mapping function.
- One sub-module, `scan_tick`: a parameterized divider that produces the one-cycle tick every `SCAN_DIV` cycles, with synchronous reset.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3.
- Reset: hold `rst` for 3 cycles with `row_n`=4'hF. Required after release: `col_n`=1110, `code`=0, `valid`=0, `held`=0.
- Clean press: pull row 2 low while column 1 is driven, hold for 200 cycles, then release. Required: exactly one `valid`, with `code`=4'b1001. `held` stays 1 until 3 all-high ticks after release.
- Bounce: row 0 low for one tick only, then high. Required: no `valid`, `held` stays 0, and the scan resumes at the next column.
- Two keys: rows 1 and 3 low on column 2. Required: a single `valid` with `code`=4'b0110.
- Reset mid-press: assert `rst` for 1 cycle while in PRESSED with the key held. Required: outputs at reset values the next cycle, then one new `valid` with the same code after a fresh debounce.
- Repeat (`KEYPAD_REPEAT_EN`, `REPEAT_PERIOD`=40): hold a key for 200 cycles after the first strobe. Required: 5 further strobes spaced exactly 40 cycles apart. The same stimulus without the macro gives a single strobe.
